// File: rtl/store_buffer_if.sv
// Store-buffer bus: core store port, memory drain port, load probe and fence.
interface store_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int AWIDTH = 30
);
   logic                     in_valid;
   logic                     in_ready;
   logic [AWIDTH-1:0]        in_addr;
   logic [3:0]               in_we;
   logic [31:0]              in_data;
   logic                     mem_req;
   logic [AWIDTH-1:0]        mem_addr;
   logic [3:0]               mem_we;
   logic [31:0]              mem_wdata;
   logic                     mem_ack;
   logic                     ld_chk_valid;
   logic [AWIDTH-1:0]        ld_chk_addr;
   logic                     ld_hazard;
   logic                     fence;
   logic                     fence_busy;
   logic                     empty;
   logic [$clog2(DEPTH):0]   count;

   // Environment side: core pipeline plus memory port
   modport master (
      output in_valid, in_addr, in_we, in_data, mem_ack, ld_chk_valid, ld_chk_addr, fence,
      input  in_ready, mem_req, mem_addr, mem_we, mem_wdata, ld_hazard, fence_busy, empty, count
   );

   // Buffer side
   modport slave (
      input  in_valid, in_addr, in_we, in_data, mem_ack, ld_chk_valid, ld_chk_addr, fence,
      output in_ready, mem_req, mem_addr, mem_we, mem_wdata, ld_hazard, fence_busy, empty, count
   );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer: queues byte-masked word stores, coalesces into the
// youngest non-head entry, drains to memory over req/ack, flags load hazards.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int AWIDTH = 30
) (
   input logic           clk,
   input logic           rst,
   store_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AWIDTH-1:0] e_addr [DEPTH];
   logic [3:0]        e_we   [DEPTH];
   logic [31:0]       e_data [DEPTH];
   logic [DEPTH-1:0]  e_valid;

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] yng_ptr;
   logic [CW-1:0] cnt;

   logic full;
   logic is_empty;
   logic do_accept;
   logic do_coal;
   logic do_push;
   logic do_pop;
   logic hz_any;

   // Control decode: acceptance, coalesce vs. new entry, pop
   always_comb begin
      full      = (cnt == CW'(DEPTH));
      is_empty  = (cnt == '0);
      yng_ptr   = wr_ptr - PW'(1);
      do_accept = bus.in_valid & ~full & (|bus.in_we);
      // Requiring two entries keeps a merge away from the head, which may be in flight
      do_coal   = do_accept & (cnt >= CW'(2)) & (e_addr[yng_ptr] == bus.in_addr);
      do_push   = do_accept & ~do_coal;
      do_pop    = ~is_empty & bus.mem_ack;
   end

   // Pointers, occupancy and valid bits; reset discards all pending entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         cnt     <= '0;
         e_valid <= '0;
      end else begin
         if (do_push) begin
            wr_ptr          <= wr_ptr + PW'(1);
            e_valid[wr_ptr] <= 1'b1;
         end
         if (do_pop) begin
            rd_ptr          <= rd_ptr + PW'(1);
            e_valid[rd_ptr] <= 1'b0;
         end
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   // Entry payload: new write at wr_ptr or byte-wise merge into the youngest entry
   always_ff @(posedge clk) begin
      if (do_coal) begin
         e_we[yng_ptr] <= e_we[yng_ptr] | bus.in_we;
         for (int unsigned b = 0; b < 4; b++) begin
            if (bus.in_we[b]) e_data[yng_ptr][8*b +: 8] <= bus.in_data[8*b +: 8];
         end
      end else if (do_push) begin
         e_addr[wr_ptr] <= bus.in_addr;
         e_we[wr_ptr]   <= bus.in_we;
         e_data[wr_ptr] <= bus.in_data;
      end
   end

   // Load probe against every valid entry, head included
   always_comb begin
      hz_any = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (e_valid[i] && (e_addr[i] == bus.ld_chk_addr)) hz_any = 1'b1;
      end
   end

   assign bus.in_ready   = ~full;
   assign bus.mem_req    = ~is_empty;
   assign bus.mem_addr   = e_addr[rd_ptr];
   assign bus.mem_we     = e_we[rd_ptr];
   assign bus.mem_wdata  = e_data[rd_ptr];
   assign bus.ld_hazard  = bus.ld_chk_valid & hz_any;
   assign bus.fence_busy = bus.fence & ~is_empty;
   assign bus.empty      = is_empty;
   assign bus.count      = cnt;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
   localparam int DEPTH  = 4;
   localparam int AWIDTH = 30;

   typedef struct {
      logic [AWIDTH-1:0] addr;
      logic [3:0]        we;
      logic [31:0]       data;
   } ent_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   ent_t q[$];

   store_buffer_if #(.DEPTH(DEPTH), .AWIDTH(AWIDTH)) bus ();

   store_buffer #(.DEPTH(DEPTH), .AWIDTH(AWIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic exp_hazard();
      logic h = 1'b0;
      foreach (q[i]) if (q[i].addr == bus.ld_chk_addr) h = 1'b1;
      return bus.ld_chk_valid & h;
   endfunction

   // Advance one clock, applying the buffer's rules to the model at the edge
   task automatic tick();
      logic pop, acc, coal;
      @(posedge clk);
      pop  = (q.size() != 0) && bus.mem_ack;
      acc  = bus.in_valid && (q.size() < DEPTH) && (bus.in_we != 4'h0);
      coal = acc && (q.size() >= 2) && (q[$].addr == bus.in_addr);
      if (coal) begin
         for (int b = 0; b < 4; b++)
            if (bus.in_we[b]) q[$].data[8*b +: 8] = bus.in_data[8*b +: 8];
         q[$].we = q[$].we | bus.in_we;
      end
      if (pop) void'(q.pop_front());
      if (acc && !coal) q.push_back('{addr: bus.in_addr, we: bus.in_we, data: bus.in_data});
      @(negedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.in_valid     = 1'b0;
      bus.in_addr      = '0;
      bus.in_we        = 4'h0;
      bus.in_data      = '0;
      bus.mem_ack      = 1'b0;
      bus.ld_chk_valid = 1'b0;
      bus.ld_chk_addr  = '0;
      bus.fence        = 1'b0;
   endtask

   task automatic store(input logic [AWIDTH-1:0] a, input logic [3:0] we, input logic [31:0] d);
      bus.in_valid = 1'b1;
      bus.in_addr  = a;
      bus.in_we    = we;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      drive_idle();
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_addr  = 30'h5;
      bus.in_we    = 4'hF;
      bus.in_data  = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
      bus.in_valid = 1'b0;
      #1;
      rst = 1'b0;
      q.delete();
      tick();
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL post_reset_count got=%0d exp=0", bus.count); end
   endtask

   task automatic test_fill_drain();
      drive_idle();
      for (int i = 0; i < 4; i++) store(30'h10 + 30'(i), 4'hF, 32'hA000_0000 + 32'(i));
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
      checks++; if (bus.mem_addr !== 30'h10) begin errors++; $display("FAIL fill_head got=%h exp=10", bus.mem_addr); end
      store(30'h14, 4'hF, 32'h5555_5555);
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fifth_held count got=%0d exp=4", bus.count); end
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h10 + 30'(i) || bus.mem_wdata !== 32'hA000_0000 + 32'(i))
            begin errors++; $display("FAIL drain_order[%0d] got req=%b addr=%h data=%h exp req=1 addr=%h", i, bus.mem_req, bus.mem_addr, bus.mem_wdata, 30'h10 + 30'(i)); end
         tick();
      end
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
   endtask

   task automatic test_coalesce();
      drive_idle();
      store(30'h20, 4'b1111, 32'h11223344);
      store(30'h30, 4'b0001, 32'h000000AA);
      store(30'h30, 4'b0100, 32'h00BB0000);
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL coalesce_count got=%0d exp=2", bus.count); end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.mem_addr !== 30'h30 || bus.mem_we !== 4'b0101 || bus.mem_wdata !== 32'h00BB00AA)
         begin errors++; $display("FAIL coalesce_entry got addr=%h we=%b data=%h exp addr=30 we=0101 data=00bb00aa", bus.mem_addr, bus.mem_we, bus.mem_wdata); end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      #1;
   endtask

   task automatic test_head_no_coalesce();
      drive_idle();
      store(30'h50, 4'hF, 32'h12345678);
      store(30'h50, 4'b0001, 32'h000000EE);
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL head_nocoal_count got=%0d exp=2", bus.count); end
      checks++; if (bus.mem_we !== 4'hF || bus.mem_wdata !== 32'h12345678)
         begin errors++; $display("FAIL head_nocoal_first got we=%b data=%h exp we=1111 data=12345678", bus.mem_we, bus.mem_wdata); end
      bus.mem_ack = 1'b1;
      tick();
      checks++; if (bus.mem_addr !== 30'h50 || bus.mem_we !== 4'b0001 || bus.mem_wdata[7:0] !== 8'hEE)
         begin errors++; $display("FAIL head_nocoal_second got addr=%h we=%b data=%h exp addr=50 we=0001", bus.mem_addr, bus.mem_we, bus.mem_wdata); end
      tick();
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL head_nocoal_empty got=%b exp=1", bus.empty); end
   endtask

   task automatic test_back_to_back();
      drive_idle();
      store(30'h60, 4'hF, 32'h60);
      store(30'h61, 4'hF, 32'h61);
      bus.mem_ack  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_addr  = 30'h62;
      bus.in_we    = 4'hF;
      bus.in_data  = 32'h62;
      tick();
      bus.in_valid = 1'b0;
      bus.mem_ack  = 1'b0;
      #1;
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL pushpop_count got=%0d exp=2", bus.count); end
      checks++; if (bus.mem_addr !== 30'h61) begin errors++; $display("FAIL pushpop_head got=%h exp=61", bus.mem_addr); end
      bus.mem_ack = 1'b1;
      repeat (2) tick();
      bus.mem_ack = 1'b0;
      #1;
   endtask

   task automatic test_hazard_fence();
      int cyc;
      drive_idle();
      bus.in_valid     = 1'b1;
      bus.in_addr      = 30'h70;
      bus.in_we        = 4'hF;
      bus.ld_chk_valid = 1'b1;
      bus.ld_chk_addr  = 30'h70;
      #1;
      checks++; if (bus.ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_same_cycle got=%b exp=0", bus.ld_hazard); end
      bus.in_valid = 1'b0;
      bus.ld_chk_valid = 1'b0;
      store(30'h40, 4'hF, 32'h40404040);
      bus.ld_chk_valid = 1'b1;
      bus.ld_chk_addr  = 30'h40;
      #1;
      checks++; if (bus.ld_hazard !== 1'b1) begin errors++; $display("FAIL hazard_hit got=%b exp=1", bus.ld_hazard); end
      bus.ld_chk_addr = 30'h41;
      #1;
      checks++; if (bus.ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_miss got=%b exp=0", bus.ld_hazard); end
      bus.ld_chk_addr = 30'h40;
      bus.mem_ack     = 1'b1;
      bus.fence       = 1'b1;
      #1;
      checks++; if (bus.ld_hazard !== 1'b1) begin errors++; $display("FAIL hazard_ack_cycle got=%b exp=1", bus.ld_hazard); end
      checks++; if (bus.fence_busy !== 1'b1) begin errors++; $display("FAIL fence_busy_set got=%b exp=1", bus.fence_busy); end
      cyc = 0;
      while (bus.empty !== 1'b1 && cyc < 10) begin
         tick();
         cyc++;
      end
      checks++; if (cyc >= 10) begin errors++; $display("FAIL fence_timeout got cycles=%0d exp <10", cyc); end
      checks++; if (bus.fence_busy !== 1'b0) begin errors++; $display("FAIL fence_busy_clear got=%b exp=0", bus.fence_busy); end
      drive_idle();
      #1;
   endtask

   task automatic test_reset_midop();
      drive_idle();
      store(30'h80, 4'hF, 32'h1);
      store(30'h81, 4'hF, 32'h2);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.mem_req !== 1'b0 || bus.count !== 3'd0)
         begin errors++; $display("FAIL reset_midop got req=%b count=%0d exp req=0 count=0", bus.mem_req, bus.count); end
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         bus.in_valid     = 1'($urandom_range(0, 1));
         bus.in_addr      = 30'h100 + 30'($urandom_range(0, 3));
         bus.in_we        = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         bus.in_data      = $urandom;
         bus.mem_ack      = ($urandom_range(0, 2) == 0);
         bus.ld_chk_valid = 1'($urandom_range(0, 1));
         bus.ld_chk_addr  = 30'h100 + 30'($urandom_range(0, 4));
         bus.fence        = 1'($urandom_range(0, 1));
         #1;
         checks++; if (bus.count !== 3'(q.size()) || bus.empty !== (q.size() == 0) || bus.in_ready !== (q.size() < DEPTH))
            begin errors++; $display("FAIL rnd_status[%0d] got count=%0d empty=%b ready=%b exp count=%0d", n, bus.count, bus.empty, bus.in_ready, q.size()); end
         checks++; if (bus.mem_req !== (q.size() != 0) || bus.fence_busy !== (bus.fence && q.size() != 0))
            begin errors++; $display("FAIL rnd_req[%0d] got req=%b fbusy=%b exp req=%b", n, bus.mem_req, bus.fence_busy, q.size() != 0); end
         checks++; if (bus.ld_hazard !== exp_hazard())
            begin errors++; $display("FAIL rnd_hazard[%0d] got=%b exp=%b", n, bus.ld_hazard, exp_hazard()); end
         if (q.size() != 0) begin
            checks++; if (bus.mem_addr !== q[0].addr || bus.mem_we !== q[0].we || bus.mem_wdata !== q[0].data)
               begin errors++; $display("FAIL rnd_head[%0d] got %h/%b/%h exp %h/%b/%h", n, bus.mem_addr, bus.mem_we, bus.mem_wdata, q[0].addr, q[0].we, q[0].data); end
         end
         tick();
      end
      drive_idle();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      drive_idle();
      test_reset();
      test_fill_drain();
      test_coalesce();
      test_head_no_coalesce();
      test_back_to_back();
      test_hazard_fence();
      test_reset_midop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
